// File: rtl/rv_decode_pkg.sv
// rtl/rv_decode_pkg.sv - RV32I decode constants, ALU control encoding and decode bundle type
package rv_decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] CLS_BASE   = 2'b00;
    localparam logic [1:0] CLS_ALT    = 2'b01;
    localparam logic [1:0] CLS_BRANCH = 2'b10;
    localparam logic [1:0] CLS_PASS_A = 2'b11;

    typedef enum logic [1:0] {
        A_RS1  = 2'b00,
        A_PC   = 2'b01,
        A_PC4  = 2'b10,
        A_ZERO = 2'b11
    } op_a_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  alu_control;
        logic        branch_op;
        op_a_sel_e   op_a_sel;
        logic        op_b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } decode_bundle_t;

    function automatic logic [5:0] alu_ctrl(input logic [1:0] cls, input logic [2:0] f3);
        return {1'b0, cls, f3};
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational RV32I instruction to decode bundle
module alu_ctrl_decode
    import rv_decode_pkg::*;
(
    input  logic [31:0]    pc,
    input  logic [31:0]    instr,
    output decode_bundle_t bundle
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] shamt;
    logic [1:0]  cls;
    logic        ill;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign shamt  = {27'b0, instr[24:20]};

    always_comb begin
        bundle     = '0;
        bundle.pc  = pc;
        bundle.rs1 = instr[19:15];
        bundle.rs2 = instr[24:20];
        bundle.rd  = instr[11:7];
        cls        = CLS_BASE;
        ill        = 1'b0;
        case (opcode)
            OPC_OP: begin
                ill = !(f7 == F7_BASE || f7 == F7_ALT);
                if (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SRL))
                    cls = CLS_ALT;
                bundle.alu_control = alu_ctrl(cls, f3);
                bundle.reg_write   = 1'b1;
            end
            OPC_OP_IMM: begin
                bundle.op_b_sel  = 1'b1;
                bundle.reg_write = 1'b1;
                if (f3 == F3_SLL) begin
                    ill        = (f7 != F7_BASE);
                    bundle.imm = shamt;
                end else if (f3 == F3_SRL) begin
                    ill        = !(f7 == F7_BASE || f7 == F7_ALT);
                    bundle.imm = shamt;
                    if (instr[30])
                        cls = CLS_ALT;
                end else begin
                    bundle.imm = imm_i;
                end
                bundle.alu_control = alu_ctrl(cls, f3);
            end
            OPC_BRANCH: begin
                ill = !(f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
                bundle.alu_control = alu_ctrl(CLS_BRANCH, f3);
                bundle.branch_op   = 1'b1;
                bundle.imm         = imm_b;
            end
            OPC_JAL, OPC_JALR: begin
                ill = (opcode == OPC_JALR) && (f3 != F3_ADD);
                bundle.alu_control = alu_ctrl(CLS_PASS_A, F3_ADD);
                bundle.op_a_sel    = A_PC4;
                bundle.op_b_sel    = 1'b1;
                bundle.imm         = (opcode == OPC_JAL) ? imm_j : imm_i;
                bundle.reg_write   = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                bundle.op_a_sel  = (opcode == OPC_LUI) ? A_ZERO : A_PC;
                bundle.op_b_sel  = 1'b1;
                bundle.imm       = imm_u;
                bundle.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                bundle.op_b_sel  = 1'b1;
                bundle.imm       = imm_i;
                bundle.mem_read  = 1'b1;
                bundle.reg_write = 1'b1;
            end
            OPC_STORE: begin
                bundle.op_b_sel  = 1'b1;
                bundle.imm       = imm_s;
                bundle.mem_write = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        // Illegal instructions keep only pc and register fields so nothing downstream acts on them.
        if (ill) begin
            bundle.alu_control = '0;
            bundle.branch_op   = 1'b0;
            bundle.op_a_sel    = A_RS1;
            bundle.op_b_sel    = 1'b0;
            bundle.imm         = '0;
            bundle.reg_write   = 1'b0;
            bundle.mem_read    = 1'b0;
            bundle.mem_write   = 1'b0;
            bundle.illegal     = 1'b1;
        end
        bundle.reg_write = bundle.reg_write & (bundle.rd != 5'd0);
    end

endmodule

// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - RV32I decode stage with registered 2-entry skid buffer
module id_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [5:0]      out_alu_control,
    output logic            out_branch_op,
    output logic [1:0]      out_op_a_sel,
    output logic            out_op_b_sel,
    output logic [31:0]     out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_illegal
);

    decode_bundle_t dec;
    decode_bundle_t main_d, main_q;
    decode_bundle_t skid_d, skid_q;
    logic           main_valid_d, main_valid_q;
    logic           skid_valid_d, skid_valid_q;
    logic           in_ready_d, in_ready_q;
    logic           accept;
    logic           retire;

    alu_ctrl_decode u_dec (
        .pc     (in_pc),
        .instr  (in_instr),
        .bundle (dec)
    );

    assign accept = in_valid & in_ready_q;
    assign retire = main_valid_q & out_ready;

    // The skid entry only fills while main is held, so main is never empty with skid full.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (retire) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept)
                    main_d = dec;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = main_valid_q;
    assign out_pc          = main_valid_q ? main_q.pc : RESET_PC;
    assign out_alu_control = main_q.alu_control;
    assign out_branch_op   = main_q.branch_op;
    assign out_op_a_sel    = main_q.op_a_sel;
    assign out_op_b_sel    = main_q.op_b_sel;
    assign out_imm         = main_q.imm;
    assign out_rs1         = main_q.rs1;
    assign out_rs2         = main_q.rs2;
    assign out_rd          = main_q.rd;
    assign out_reg_write   = main_q.reg_write;
    assign out_mem_read    = main_q.mem_read;
    assign out_mem_write   = main_q.mem_write;
    assign out_illegal     = main_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - randomized self-checking bench for id_decode_stage
module tb_id_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [5:0]  out_alu_control;
    logic        out_branch_op;
    logic [1:0]  out_op_a_sel;
    logic        out_op_b_sel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_illegal;

    int tests  = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  ctrl;
        logic        br;
        logic [1:0]  a;
        logic        b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wr;
        logic        mr;
        logic        mw;
        logic        ill;
    } exp_t;

    exp_t q[$];

    always #5 clock = ~clock;

    id_decode_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_alu_control(out_alu_control), .out_branch_op(out_branch_op),
        .out_op_a_sel(out_op_a_sel), .out_op_b_sel(out_op_b_sel), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_illegal(out_illegal)
    );

    // Reference decoder written from the ISA rules: each opcode selects a format and flags.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        int   f3;
        int   f7;
        e     = '0;
        e.pc  = pc;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        f3    = int'(ins[14:12]);
        f7    = int'(ins[31:25]);
        case (ins[6:0])
            7'h33: begin
                e.ill  = !(f7 == 0 || f7 == 32);
                e.ctrl = 6'((f7 == 32 && (f3 == 0 || f3 == 5)) ? 8 + f3 : f3);
                e.wr   = 1'b1;
            end
            7'h13: begin
                e.b = 1'b1; e.wr = 1'b1;
                e.ctrl = 6'(f3);
                if (f3 == 1) begin
                    e.ill = (f7 != 0); e.imm = 32'(ins[24:20]);
                end else if (f3 == 5) begin
                    e.ill = !(f7 == 0 || f7 == 32); e.imm = 32'(ins[24:20]);
                    if (f7 == 32) e.ctrl = 6'd13;
                end else begin
                    e.imm = 32'($signed(ins[31:20]));
                end
            end
            7'h63: begin
                e.ill = (f3 == 2 || f3 == 3); e.ctrl = 6'(16 + f3); e.br = 1'b1;
                e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'h6F: begin
                e.ctrl = 6'd24; e.a = 2'd2; e.b = 1'b1; e.wr = 1'b1;
                e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'h67: begin
                e.ill = (f3 != 0); e.ctrl = 6'd24; e.a = 2'd2; e.b = 1'b1; e.wr = 1'b1;
                e.imm = 32'($signed(ins[31:20]));
            end
            7'h37, 7'h17: begin
                e.a = (ins[6:0] == 7'h37) ? 2'd3 : 2'd1; e.b = 1'b1; e.wr = 1'b1;
                e.imm = ins & 32'hFFFFF000;
            end
            7'h03: begin
                e.b = 1'b1; e.mr = 1'b1; e.wr = 1'b1; e.imm = 32'($signed(ins[31:20]));
            end
            7'h23: begin
                e.b = 1'b1; e.mw = 1'b1; e.imm = 32'($signed({ins[31:25], ins[11:7]}));
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.ctrl = '0; e.br = 1'b0; e.a = '0; e.b = 1'b0; e.imm = '0;
            e.wr = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
        end
        if (e.rd == 0) e.wr = 1'b0;
        return e;
    endfunction

    function automatic exp_t observe();
        return {out_pc, out_alu_control, out_branch_op, out_op_a_sel, out_op_b_sel, out_imm,
                out_rs1, out_rs2, out_rd, out_reg_write, out_mem_read, out_mem_write, out_illegal};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  opc;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: opc = 7'h33;  1: opc = 7'h13;  2: opc = 7'h63;  3: opc = 7'h6F;
            4: opc = 7'h67;  5: opc = 7'h37;  6: opc = 7'h17;  7: opc = 7'h03;
            8: opc = 7'h23;  default: opc = r[6:0];
        endcase
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return {r[31:7], opc};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] ins);
        in_valid = 1'b1; in_pc = pc; in_instr = ins;
        tests++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL send_ready pc=%h got in_ready=%b want 1", pc, in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_hs got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        tests++;
        if (observe() !== exp_t'(0)) begin
            errors++; $display("FAIL reset_payload got %h want 0", observe());
        end
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        send(32'h100, 32'h403100B3);
        tests++;
        if (out_valid !== 1'b1 || out_alu_control !== 6'b001000 || out_op_a_sel !== 2'b00 ||
            out_op_b_sel !== 1'b0 || out_rd !== 5'd1 || out_reg_write !== 1'b1 || out_pc !== 32'h100) begin
            errors++; $display("FAIL sub got v=%b ctrl=%b a=%b b=%b rd=%0d wr=%b want 1/001000/00/0/1/1",
                               out_valid, out_alu_control, out_op_a_sel, out_op_b_sel, out_rd, out_reg_write);
        end
        send(32'h104, 32'h40335293);
        tests++;
        if (out_valid !== 1'b1 || out_alu_control !== 6'b001101 || out_op_b_sel !== 1'b1 ||
            out_imm !== 32'd3 || out_rd !== 5'd5) begin
            errors++; $display("FAIL srai got v=%b ctrl=%b b=%b imm=%h rd=%0d want 1/001101/1/3/5",
                               out_valid, out_alu_control, out_op_b_sel, out_imm, out_rd);
        end
        send(32'h108, 32'h00208463);
        tests++;
        if (out_valid !== 1'b1 || out_alu_control !== 6'b010000 || out_branch_op !== 1'b1 ||
            out_imm !== 32'd8 || out_reg_write !== 1'b0) begin
            errors++; $display("FAIL beq got v=%b ctrl=%b br=%b imm=%h wr=%b want 1/010000/1/8/0",
                               out_valid, out_alu_control, out_branch_op, out_imm, out_reg_write);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        send(32'h200, 32'hFFFFFFFF);
        tests++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_reg_write !== 1'b0 || out_mem_read !== 1'b0 ||
            out_mem_write !== 1'b0 || out_branch_op !== 1'b0 || out_alu_control !== 6'd0) begin
            errors++; $display("FAIL illegal got v=%b ill=%b wr=%b mr=%b mw=%b br=%b ctrl=%b want 1/1/0/0/0/0/0",
                               out_valid, out_illegal, out_reg_write, out_mem_read, out_mem_write,
                               out_branch_op, out_alu_control);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(32'h300, 32'h00000013);
        send(32'h304, 32'h00100093);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h300) begin
            errors++; $display("FAIL bp_full got rdy=%b v=%b pc=%h want 0/1/300", in_ready, out_valid, out_pc);
        end
        in_valid = 1'b1; in_pc = 32'h308; in_instr = 32'h00200113;
        tick();
        tests++;
        if (in_ready !== 1'b0 || out_pc !== 32'h300) begin
            errors++; $display("FAIL bp_hold got rdy=%b pc=%h want 0/300", in_ready, out_pc);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_pc !== 32'h304 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_second got pc=%h rdy=%b v=%b want 304/1/1", out_pc, in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_pc !== 32'h308 || out_valid !== 1'b1 || out_rd !== 5'd2) begin
            errors++; $display("FAIL bp_third got pc=%h v=%b rd=%0d want 308/1/2", out_pc, out_valid, out_rd);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_empty got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(32'h400, 32'h00000013);
        send(32'h404, 32'h00000013);
        in_valid = 1'b1; in_pc = 32'h408; in_instr = 32'h00000013; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_quiet cycle %0d got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic acc, ret;
        q.delete();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_pc     = {$urandom, 2'b00} & 32'hFFFFFFFC;
            in_instr  = rand_instr();
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            tests++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                errors++; $display("FAIL rand_hs cycle %0d got v=%b rdy=%b want v=%b rdy=%b",
                                   c, out_valid, in_ready, q.size() != 0, q.size() < 2);
            end
            if (q.size() != 0) begin
                tests++;
                if (observe() !== q[0]) begin
                    errors++; $display("FAIL rand_bundle cycle %0d got %h want %h", c, observe(), q[0]);
                end
            end
            acc = in_valid && (q.size() < 2);
            ret = out_ready && (q.size() != 0);
            if (flush) begin
                q.delete();
            end else begin
                if (ret) void'(q.pop_front());
                if (acc) q.push_back(model(in_pc, in_instr));
            end
            tick();
        end
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(32'h500, 32'h00000013);
        send(32'h504, 32'h00000013);
        #3 reset = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0) begin
            errors++; $display("FAIL reset_mid got v=%b rdy=%b pc=%h want 0/1/0", out_valid, in_ready, out_pc);
        end
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_after got out_valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
        tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
